decoder_scan_nto2n: RTL and testbench
=====================================

// Module: decoder_scan_nto2n
// PURPOSE
//  Registered, parametrised N-to-2^N one-hot decoder with enable and selectable polarity.
//  Two modes: DIRECT, where a select is accepted by valid/ready handshake, and SCAN,
//  where an internal counter steps through every output with a programmable dwell.
//  Drives multiplexed display digits, keypad rows and chip-selects from one block.
// PARAMETERS
//  N          2  select width; y has 2**N bits (N >= 1)
//  DWELL      4  SCAN mode: cycles each output stays active (DWELL >= 1)
//  ACTIVE_LOW 1  1: active output = 0, inactive = 1; 0: active = 1, inactive = 0
// PORTS
//  clk        in   1       single clock; all state changes on rising edge
//  reset      in   1       synchronous, active-high reset
//  en         in   1       0 forces all outputs inactive
//  mode       in   1       0 = DIRECT, 1 = SCAN
//  sel_valid  in   1       DIRECT: sel is valid this cycle
//  sel        in   N       DIRECT: output index to activate
//  sel_ready  out  1       DIRECT: block accepts sel this cycle
//  y          out  2**N    decoded outputs, registered, polarity per ACTIVE_LOW
//  cur_sel    out  N       index of the active output (0 when none is active)
//  wrap       out  1       SCAN: 1-cycle pulse when cur_sel steps 2**N-1 -> 0
// BEHAVIOUR
//  Reset values: y all inactive, cur_sel 0, sel_ready 0, wrap 0, state IDLE, dwell_cnt 0.
//  States: IDLE, DIRECT, SCAN, BLANK (BLANK exists only with the macro).
//  Every output is a register; no combinational path from inputs to y.
//  IDLE: y inactive. Moves to DIRECT or SCAN, per mode, on the first cycle en=1.
//  en=0 in any state: next cycle IDLE, y inactive, cur_sel 0, dwell_cnt 0, wrap 0.
//  DIRECT:
//   - sel_ready = 1 while in DIRECT (and not BLANK).
//   - On a handshake (sel_valid & sel_ready) y shows the one-hot of sel on the next edge.
//     Latency is 1 cycle.
//   - y holds its last value until the next handshake.
//   - On entry to DIRECT, y is inactive until the first handshake.
//  SCAN:
//   - sel_ready = 0 and sel is ignored.
//   - On entry: cur_sel = 0, output 0 active, dwell_cnt = 0.
//   - Each output stays active for exactly DWELL cycles, then cur_sel increments.
//   - From 2**N-1, cur_sel wraps to 0 and wrap pulses for 1 cycle, aligned with the
//     first cycle of output 0.
//   - Full period = DWELL * 2**N cycles (BLANK cycles extra when enabled).
//  Mode change while en=1: takes effect on the next edge.
//   - DIRECT -> SCAN restarts at index 0.
//   - SCAN -> DIRECT drives y inactive until the next handshake.
//  A handshake in the cycle where mode goes to 1 is discarded.
//  Simultaneous reset and en/sel: reset wins.
//  Exactly one bit of y is active at any time, or none.
// CONFIGURATION
//  Macro DECODER_SCAN_BLANK_EN
//  Defined: every change of the active output index (DIRECT handshake to a different sel,
//   SCAN step, wrap) inserts one BLANK cycle first.
//   - During BLANK: y all inactive and sel_ready = 0; then the new output is driven.
//   - DIRECT latency becomes 2 cycles for a changed index; it stays 1 for the same index.
//   - SCAN period = (DWELL+1) * 2**N.
//   - wrap aligns with the first active cycle of output 0, not with BLANK.
//  Undefined: no BLANK state; outputs switch directly, with the timings above.
// STRUCTURE
//  Shared package decoder_pkg:
//   - state typedef (IDLE/DIRECT/SCAN/BLANK)
//   - MODE_DIRECT / MODE_SCAN constants
//   - function onehot_dec(sel, active_low), returning the 2**N-bit pattern
//  Sub-module scan_dwell_counter: dwell counter plus index counter; outputs step and wrap.
//  Top level holds the FSM, handshake and output register.
// TESTING (N=2, DWELL=3, ACTIVE_LOW=1 unless stated)
//  1 reset=1 for 2 cycles with en=1 -> y=4'b1111, sel_ready=0, cur_sel=0, wrap=0.
//  2 DIRECT: handshakes sel=0,1,2,3 -> y=1110, 1101, 1011, 0111, each 1 cycle after its
//    handshake; sel_valid=0 -> y holds 0111.
//  3 SCAN: en=1 -> y=1110 x3, 1101 x3, 1011 x3, 0111 x3, then 1110 with wrap=1 on cycle 13;
//    period 12.
//  4 en=0 mid-scan at cur_sel=2 -> next cycle y=1111, cur_sel=0.
//    en=1 again -> scan restarts at output 0, full dwell.
//  5 ACTIVE_LOW=0, N=3: DIRECT sel=5 -> y=8'b0010_0000.
//    reset asserted mid-dwell -> y=0 next cycle.
//  6 DECODER_SCAN_BLANK_EN, DIRECT 1 -> 2: y=1101, 1111, 1011.
//    SCAN period 16; sel_ready=0 during BLANK; never two active bits.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state encoding, mode constants and one-hot decode helper
package decoder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DIRECT = 2'd1;
    localparam state_t ST_SCAN   = 2'd2;
    localparam state_t ST_BLANK  = 2'd3;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the helper supports; callers zero-extend and slice down.
    localparam int MAX_N = 8;
    localparam int MAX_W = 2 ** MAX_N;

    // One active bit at position sel, polarity chosen by active_low.
    function automatic logic [MAX_W-1:0] onehot_dec(input logic [MAX_N-1:0] sel,
                                                    input logic             active_low);
        logic [MAX_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/decoder_scan_nto2n_counter.sv
// rtl/decoder_scan_nto2n_counter.sv - scan dwell and index counter with step/wrap strobes
module scan_dwell_counter
    import decoder_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         advance,
    output logic [N-1:0] idx,
    output logic         step,
    output logic         wrap
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] LAST = DW'(DWELL - 1);

    logic [DW-1:0] dwell_cnt;

    // step fires on the last dwell cycle; wrap when that step leaves the top index
    assign step = advance && (dwell_cnt == LAST);
    assign wrap = step && (&idx);

    // Count dwell cycles while advancing; clear restarts at index 0, dwell 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            dwell_cnt <= '0;
            idx       <= '0;
        end else if (step) begin
            dwell_cnt <= '0;
            idx       <= idx + 1'b1;
        end else if (advance) begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan_nto2n.sv
// rtl/decoder_scan_nto2n.sv - registered N-to-2^N decoder, DIRECT/SCAN modes, optional BLANK via DECODER_SCAN_BLANK_EN
module decoder_scan_nto2n
    import decoder_pkg::*;
#(
    parameter int N          = 2,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic              sel_valid,
    input  logic [N-1:0]      sel,
    output logic              sel_ready,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      cur_sel,
    output logic              wrap
);

    localparam int W = 2 ** N;
    localparam logic [W-1:0] Y_OFF = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    state_t       state;
    logic         scan_live;
    logic         direct_live;
    logic         hs;
    logic         cnt_clear;
    logic         cnt_advance;
    logic         cnt_step;
    logic         cnt_wrap;
    logic [N-1:0] cnt_idx;
    logic [N-1:0] idx_next;

`ifdef DECODER_SCAN_BLANK_EN
    logic         blank_scan;
    logic         wrap_pend;
    logic [N-1:0] pend_sel;
`endif

    function automatic logic [W-1:0] dec(input logic [N-1:0] s);
        logic [MAX_N-1:0] s_ext;
        logic [MAX_W-1:0] full;
        s_ext        = '0;
        s_ext[N-1:0] = s;
        full         = onehot_dec(s_ext, ACTIVE_LOW != 0);
        return full[W-1:0];
    endfunction

    // A BLANK cycle belongs to whichever mode inserted it.
`ifdef DECODER_SCAN_BLANK_EN
    assign scan_live   = (state == ST_SCAN)   || ((state == ST_BLANK) &&  blank_scan);
    assign direct_live = (state == ST_DIRECT) || ((state == ST_BLANK) && !blank_scan);
`else
    assign scan_live   = (state == ST_SCAN);
    assign direct_live = (state == ST_DIRECT);
`endif

    assign hs          = sel_valid && sel_ready;
    assign cnt_clear   = !(en && (mode == MODE_SCAN) && scan_live);
    assign cnt_advance = en && (mode == MODE_SCAN) && (state == ST_SCAN);
    assign idx_next    = cnt_idx + 1'b1;

    scan_dwell_counter #(
        .N     (N),
        .DWELL (DWELL)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .idx     (cnt_idx),
        .step    (cnt_step),
        .wrap    (cnt_wrap)
    );

    // FSM, handshake and output registers; en=0 behaves like reset.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            state     <= ST_IDLE;
            y         <= Y_OFF;
            cur_sel   <= '0;
            sel_ready <= 1'b0;
            wrap      <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
            blank_scan <= 1'b0;
            wrap_pend  <= 1'b0;
            pend_sel   <= '0;
`endif
        end else begin
            wrap <= 1'b0;
            if (mode == MODE_SCAN) begin
                if (!scan_live) begin
                    // entering SCAN from anywhere restarts at output 0; pending handshake dropped
                    state     <= ST_SCAN;
                    y         <= dec('0);
                    cur_sel   <= '0;
                    sel_ready <= 1'b0;
                end else if (state == ST_SCAN) begin
                    if (cnt_step) begin
`ifdef DECODER_SCAN_BLANK_EN
                        state      <= ST_BLANK;
                        y          <= Y_OFF;
                        cur_sel    <= '0;
                        blank_scan <= 1'b1;
                        wrap_pend  <= cnt_wrap;
`else
                        y       <= dec(idx_next);
                        cur_sel <= idx_next;
                        wrap    <= cnt_wrap;
`endif
                    end
                end else begin
`ifdef DECODER_SCAN_BLANK_EN
                    // leaving a scan BLANK: counter index already advanced
                    state   <= ST_SCAN;
                    y       <= dec(cnt_idx);
                    cur_sel <= cnt_idx;
                    wrap    <= wrap_pend;
`endif
                end
            end else begin
                if (!direct_live) begin
                    state     <= ST_DIRECT;
                    y         <= Y_OFF;
                    cur_sel   <= '0;
                    sel_ready <= 1'b1;
                end else if (state == ST_DIRECT) begin
                    if (hs) begin
`ifdef DECODER_SCAN_BLANK_EN
                        if ((y != Y_OFF) && (sel != cur_sel)) begin
                            state      <= ST_BLANK;
                            y          <= Y_OFF;
                            cur_sel    <= '0;
                            sel_ready  <= 1'b0;
                            blank_scan <= 1'b0;
                            pend_sel   <= sel;
                        end else begin
                            y       <= dec(sel);
                            cur_sel <= sel;
                        end
`else
                        y       <= dec(sel);
                        cur_sel <= sel;
`endif
                    end
                end else begin
`ifdef DECODER_SCAN_BLANK_EN
                    state     <= ST_DIRECT;
                    y         <= dec(pend_sel);
                    cur_sel   <= pend_sel;
                    sel_ready <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// tb/tb_decoder_scan_nto2n.sv - directed self-checking bench for decoder_scan_nto2n
module tb_decoder_scan_nto2n;

    localparam int DWELL = 3;
`ifdef DECODER_SCAN_BLANK_EN
    localparam int SL = DWELL + 1;
`else
    localparam int SL = DWELL;
`endif
    localparam int PERIOD = 4 * SL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, mode, sel_valid, sel_ready, wrap;
    logic [1:0] sel, cur_sel;
    logic [3:0] y;

    logic       reset8, en8, mode8, sel_valid8, sel_ready8, wrap8;
    logic [2:0] sel8, cur_sel8;
    logic [7:0] y8;

    int checks = 0;
    int errors = 0;

    decoder_scan_nto2n #(.N(2), .DWELL(DWELL), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel(sel), .sel_ready(sel_ready), .y(y), .cur_sel(cur_sel), .wrap(wrap)
    );

    decoder_scan_nto2n #(.N(3), .DWELL(2), .ACTIVE_LOW(0)) dut8 (
        .clk(clk), .reset(reset8), .en(en8), .mode(mode8), .sel_valid(sel_valid8),
        .sel(sel8), .sel_ready(sel_ready8), .y(y8), .cur_sel(cur_sel8), .wrap(wrap8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] scan_y(input int c);
        int off, k;
        off = (c - 1) % SL;
        k   = ((c - 1) / SL) % 4;
        return (off < DWELL) ? ~(4'b0001 << k) : 4'b1111;
    endfunction

    function automatic logic [1:0] scan_sel(input int c);
        int off, k;
        off = (c - 1) % SL;
        k   = ((c - 1) / SL) % 4;
        return (off < DWELL) ? 2'(k) : 2'd0;
    endfunction

    initial begin
        reset = 1'b1; en = 1'b1; mode = 1'b0; sel_valid = 1'b0; sel = 2'd0;
        reset8 = 1'b1; en8 = 1'b1; mode8 = 1'b0; sel_valid8 = 1'b0; sel8 = 3'd0;

        // reset with en=1
        tick; tick;
        check("rst_y", 32'(y), 32'h0000000f);
        check("rst_ready", 32'(sel_ready), 0);
        check("rst_cur_sel", 32'(cur_sel), 0);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_y8", 32'(y8), 0);

        // IDLE -> DIRECT, inactive until first handshake
        reset = 1'b0;
        tick;
        check("dir_entry_y", 32'(y), 32'h0000000f);
        check("dir_entry_ready", 32'(sel_ready), 1);

        // DIRECT handshakes 0..3
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i); sel_valid = 1'b1;
            tick;
            sel_valid = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
            if (i != 0) begin
                check("dir_blank_y", 32'(y), 32'h0000000f);
                check("dir_blank_ready", 32'(sel_ready), 0);
                tick;
            end
`endif
            check("dir_y", 32'(y), 32'(~(4'b0001 << i) & 4'hf));
            check("dir_cur_sel", 32'(cur_sel), 32'(i));
        end
        tick; tick;
        check("dir_hold_y", 32'(y), 32'h00000007);
        check("dir_hold_ready", 32'(sel_ready), 1);

        // same index again: one-cycle latency, no blank
        sel = 2'd3; sel_valid = 1'b1;
        tick;
        sel_valid = 1'b0;
        check("dir_same_y", 32'(y), 32'h00000007);
        check("dir_same_ready", 32'(sel_ready), 1);

        // handshake in the cycle mode goes to SCAN is discarded
        sel = 2'd1; sel_valid = 1'b1; mode = 1'b1;
        tick;
        sel_valid = 1'b0;
        check("scan_entry_ready", 32'(sel_ready), 0);
        for (int c = 1; c <= PERIOD + 1; c++) begin
            check("scan_y", 32'(y), 32'(scan_y(c)));
            check("scan_cur_sel", 32'(cur_sel), 32'(scan_sel(c)));
            check("scan_wrap", 32'(wrap), 32'(c == PERIOD + 1));
            check("scan_ready", 32'(sel_ready), 0);
            if (c <= PERIOD) tick;
        end

        // walk to mid-dwell of output 2, then drop en
        repeat (2 * SL + 1) tick;
        check("scan_mid_sel", 32'(cur_sel), 2);
        en = 1'b0;
        tick;
        check("en_off_y", 32'(y), 32'h0000000f);
        check("en_off_cur_sel", 32'(cur_sel), 0);
        check("en_off_wrap", 32'(wrap), 0);

        // re-enable: restart at output 0 with full dwell
        en = 1'b1;
        tick;
        for (int c = 1; c <= SL + 1; c++) begin
            check("restart_y", 32'(y), 32'(scan_y(c)));
            if (c <= SL) tick;
        end

        // SCAN -> DIRECT: inactive until a handshake
        mode = 1'b0;
        tick;
        check("scan2dir_y", 32'(y), 32'h0000000f);
        check("scan2dir_ready", 32'(sel_ready), 1);
        check("scan2dir_cur_sel", 32'(cur_sel), 0);

        // N=3, active-high instance
        reset8 = 1'b0;
        tick;
        check("n3_ready", 32'(sel_ready8), 1);
        sel8 = 3'd5; sel_valid8 = 1'b1;
        tick;
        sel_valid8 = 1'b0;
        check("n3_y", 32'(y8), 32'h00000020);
        check("n3_cur_sel", 32'(cur_sel8), 5);
        mode8 = 1'b1;
        tick;
        check("n3_scan_y", 32'(y8), 32'h00000001);
        reset8 = 1'b1;
        tick;
        check("n3_rst_y", 32'(y8), 0);
        check("n3_rst_cur_sel", 32'(cur_sel8), 0);
        check("n3_rst_ready", 32'(sel_ready8), 0);
        check("n3_rst_wrap", 32'(wrap8), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
